// File: rtl/spi_byte_slave_pkg.sv
// Shared definitions for the SPI byte slave: FSM state encoding and byte geometry.
package spi_byte_slave_pkg;

  localparam int unsigned SPI_BYTE_W = 8;
  localparam int unsigned BIT_CNT_W  = 3;

  typedef enum logic {
    SPI_ST_IDLE  = 1'b0,
    SPI_ST_SHIFT = 1'b1
  } spi_state_e;

endpackage

// File: rtl/spi_byte_slave_sync_edge.sv
// N-flop synchroniser for one asynchronous input, with single-cycle rise/fall pulses
// derived from the last two synchronised samples.
module spi_sync_edge #(
  parameter int unsigned N       = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [N-1:0] sync_q;
  logic         prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {N{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[N-2:0], async_i};
      prev_q <= sync_q[N-1];
    end
  end

  assign level_o = sync_q[N-1];
  assign rise_o  = sync_q[N-1] & ~prev_q;
  assign fall_o  = ~sync_q[N-1] & prev_q;

endmodule

// File: rtl/spi_byte_slave.sv
// SPI mode-0 byte slave: oversampled SCK/CS_N/MOSI, MSB-first deserialiser, frame byte counter.
// Define SPI_BYTE_SLAVE_MISO_EN to build the tx_shift register and drive spi_miso.
module spi_byte_slave
  import spi_byte_slave_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  spi_sck,
  input  logic                  spi_cs_n,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  output logic [SPI_BYTE_W-1:0] rx_data,
  output logic                  rx_valid,
  input  logic [SPI_BYTE_W-1:0] tx_data,
  output logic                  frame_active,
  output logic [CNT_W-1:0]      frame_bytes,
  output logic                  rx_abort
);

  logic sck_lvl, sck_rise, sck_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;

  spi_sync_edge #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
    .clk(clk), .rst_n(rst_n), .async_i(spi_sck),
    .level_o(sck_lvl), .rise_o(sck_rise), .fall_o(sck_fall)
  );

  spi_sync_edge #(.N(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .async_i(spi_cs_n),
    .level_o(cs_lvl), .rise_o(cs_rise), .fall_o(cs_fall)
  );

  spi_sync_edge #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .async_i(spi_mosi),
    .level_o(mosi_lvl), .rise_o(mosi_rise), .fall_o(mosi_fall)
  );

  logic unused_sync;
  assign unused_sync = sck_lvl ^ cs_lvl ^ mosi_rise ^ mosi_fall;

  spi_state_e             state_q, state_d;
  logic [SPI_BYTE_W-2:0]  sr_q, sr_d;
  logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [SPI_BYTE_W-1:0]  rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   rx_abort_q, rx_abort_d;
  logic [CNT_W-1:0]       frame_bytes_q, frame_bytes_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= SPI_ST_IDLE;
      sr_q          <= '0;
      bit_cnt_q     <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      rx_abort_q    <= 1'b0;
      frame_bytes_q <= '0;
    end else begin
      state_q       <= state_d;
      sr_q          <= sr_d;
      bit_cnt_q     <= bit_cnt_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      rx_abort_q    <= rx_abort_d;
      frame_bytes_q <= frame_bytes_d;
    end
  end

  // cs_n rise is tested first so a coincident sck rise is dropped.
  always_comb begin
    state_d       = state_q;
    sr_d          = sr_q;
    bit_cnt_d     = bit_cnt_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = 1'b0;
    rx_abort_d    = 1'b0;
    frame_bytes_d = frame_bytes_q;
    case (state_q)
      SPI_ST_IDLE: begin
        if (cs_fall) begin
          state_d       = SPI_ST_SHIFT;
          bit_cnt_d     = '0;
          frame_bytes_d = '0;
        end
      end
      SPI_ST_SHIFT: begin
        if (cs_rise) begin
          state_d    = SPI_ST_IDLE;
          rx_abort_d = (bit_cnt_q != '0);
        end else if (sck_rise) begin
          sr_d      = {sr_q[SPI_BYTE_W-3:0], mosi_lvl};
          bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          if (bit_cnt_q == BIT_CNT_W'(SPI_BYTE_W - 1)) begin
            rx_data_d  = {sr_q, mosi_lvl};
            rx_valid_d = 1'b1;
            bit_cnt_d  = '0;
            if (frame_bytes_q != '1) begin
              frame_bytes_d = frame_bytes_q + CNT_W'(1);
            end
          end
        end
      end
      default: state_d = SPI_ST_IDLE;
    endcase
  end

  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign rx_abort     = rx_abort_q;
  assign frame_bytes  = frame_bytes_q;
  assign frame_active = (state_q == SPI_ST_SHIFT);

`ifdef SPI_BYTE_SLAVE_MISO_EN
  logic [SPI_BYTE_W-1:0] tx_shift_q, tx_shift_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_shift_q <= '0;
    end else begin
      tx_shift_q <= tx_shift_d;
    end
  end

  // bit_cnt is 0 on the fall that follows a byte's last rise, so the freshly
  // reloaded response byte is not shifted before its MSB is sampled.
  always_comb begin
    tx_shift_d = tx_shift_q;
    case (state_q)
      SPI_ST_IDLE: begin
        if (cs_fall) tx_shift_d = tx_data;
      end
      SPI_ST_SHIFT: begin
        if (!cs_rise) begin
          if (sck_rise && bit_cnt_q == BIT_CNT_W'(SPI_BYTE_W - 1)) begin
            tx_shift_d = tx_data;
          end else if (sck_fall && bit_cnt_q != '0) begin
            tx_shift_d = {tx_shift_q[SPI_BYTE_W-2:0], 1'b0};
          end
        end
      end
      default: tx_shift_d = tx_shift_q;
    endcase
  end

  assign spi_miso = frame_active ? tx_shift_q[SPI_BYTE_W-1] : 1'b0;
`else
  logic unused_tx;
  assign unused_tx = ^{tx_data, sck_fall};
  assign spi_miso  = 1'b0;
`endif

endmodule
